// File: rtl/inst_fetch_buf.sv
// Instruction fetch unit: AXI4 INCR burst reads into a {pc, inst} prefetch FIFO.
// Supports flush/redirect and drains any burst that was in flight at the flush.
`timescale 1ns/1ps
module inst_fetch_buf #(
    parameter int          C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int          C_M_AXI_ADDR_WIDTH      = 32,
    parameter int          C_M_AXI_DATA_WIDTH      = 32,
    parameter int          C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int          C_M_AXI_RUSER_WIDTH     = 4,
    parameter int          BURST_LEN               = 4,
    parameter int          FIFO_DEPTH              = 8,
    parameter logic [31:0] RESET_PC                = 32'h0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               EXEC,
    input  logic                               STALL,
    input  logic                               FLUSH,
    input  logic [31:0]                        FLUSH_PC,
    output logic [31:0]                        I_PC,
    output logic [31:0]                        I_INST,
    output logic                               I_VALID,
    output logic                               MEM_WAIT,
    output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
    output logic [7:0]                         M_AXI_ARLEN,
    output logic [2:0]                         M_AXI_ARSIZE,
    output logic [1:0]                         M_AXI_ARBURST,
    output logic [1:0]                         M_AXI_ARLOCK,
    output logic [3:0]                         M_AXI_ARCACHE,
    output logic [2:0]                         M_AXI_ARPROT,
    output logic [3:0]                         M_AXI_ARQOS,
    output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
    output logic                               M_AXI_ARVALID,
    input  logic                               M_AXI_ARREADY,
    input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
    input  logic [1:0]                         M_AXI_RRESP,
    input  logic                               M_AXI_RLAST,
    input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
    input  logic                               M_AXI_RVALID,
    output logic                               M_AXI_RREADY
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REQ_DRAIN,
        S_DATA,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic [31:0]   fetch_pc;
    logic [31:0]   ar_addr;
    logic [7:0]    ar_len;
    logic [31:0]   beat_pc;
    logic [31:0]   pc_mem   [FIFO_DEPTH];
    logic [31:0]   inst_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          pop;
    logic          wr_en;
    logic          ar_hs;
    logic          r_hs;
    logic          can_req;
    logic [12:0]   words_left;
    logic [12:0]   req_len;
    logic [12:0]   free;
    logic          unused_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A burst never crosses a 4 KB page: clip it to the words left in the page.
    assign words_left = (13'h1000 - {1'b0, fetch_pc[11:0]}) >> 2;
    assign req_len    = (words_left < 13'(BURST_LEN)) ? words_left
                                                      : 13'(BURST_LEN);
    assign free       = 13'(FIFO_DEPTH) - 13'(count);
    assign can_req    = free >= req_len;

    assign empty    = (count == '0);
    assign I_VALID  = EXEC & ~empty;
    assign MEM_WAIT = EXEC & empty;
    assign I_PC     = empty ? 32'h0 : pc_mem[rd_ptr];
    assign I_INST   = empty ? 32'h0 : inst_mem[rd_ptr];

    assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID & M_AXI_RREADY;
    assign pop   = I_VALID & ~STALL & ~FLUSH;
    assign wr_en = (state == S_DATA) & M_AXI_RVALID & ~FLUSH;

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(ar_addr);
    assign M_AXI_ARLEN   = ar_len;
    assign M_AXI_ARSIZE  = 3'b010;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 2'b00;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARUSER  = '0;

    assign unused_ok = ^{M_AXI_RID, M_AXI_RRESP, M_AXI_RUSER, M_AXI_RDATA};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // REQ_DRAIN: address already presented when a flush hit; its data is junk.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (EXEC && !FLUSH && can_req) state_nx = S_REQ;
            end
            S_REQ: begin
                if (M_AXI_ARREADY) state_nx = FLUSH ? S_DRAIN : S_DATA;
                else if (FLUSH)    state_nx = S_REQ_DRAIN;
            end
            S_REQ_DRAIN: begin
                if (M_AXI_ARREADY) state_nx = S_DRAIN;
            end
            S_DATA: begin
                if (M_AXI_RVALID && M_AXI_RLAST) state_nx = S_IDLE;
                else if (FLUSH)                  state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (M_AXI_RVALID && M_AXI_RLAST) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        unique case (state)
            S_REQ, S_REQ_DRAIN: M_AXI_ARVALID = 1'b1;
            S_DATA, S_DRAIN:    M_AXI_RREADY  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc <= RESET_PC;
            ar_addr  <= '0;
            ar_len   <= '0;
            beat_pc  <= '0;
        end else begin
            if (state == S_IDLE && state_nx == S_REQ) begin
                ar_addr <= fetch_pc;
                ar_len  <= 8'(req_len - 13'd1);
            end
            if (ar_hs) begin
                beat_pc <= ar_addr;
            end else if (wr_en) begin
                beat_pc <= beat_pc + 32'd4;
            end
            if (FLUSH) begin
                fetch_pc <= FLUSH_PC;
            end else if (state == S_REQ && ar_hs) begin
                fetch_pc <= ar_addr + {22'b0, ar_len, 2'b00} + 32'd4;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(wr_en) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            pc_mem[wr_ptr]   <= beat_pc;
            inst_mem[wr_ptr] <= M_AXI_RDATA[31:0];
        end
    end

    logic r_hs_seen;
    assign r_hs_seen = r_hs;

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf with a simple AXI read slave.
// Memory word at byte address a reads as 32'h1000_0000 + a/4.
`timescale 1ns/1ps
module tb_inst_fetch_buf;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EXEC;
    logic        STALL;
    logic        FLUSH;
    logic [31:0] FLUSH_PC;
    logic [31:0] I_PC;
    logic [31:0] I_INST;
    logic        I_VALID;
    logic        MEM_WAIT;
    logic [0:0]  ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [1:0]  ARLOCK;
    logic [3:0]  ARCACHE;
    logic [2:0]  ARPROT;
    logic [3:0]  ARQOS;
    logic [0:0]  ARUSER;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    always #5 CLK = ~CLK;

    inst_fetch_buf dut (
        .CLK(CLK), .RST(RST), .EXEC(EXEC), .STALL(STALL),
        .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
        .I_PC(I_PC), .I_INST(I_INST), .I_VALID(I_VALID),
        .MEM_WAIT(MEM_WAIT),
        .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR),
        .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
        .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK),
        .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT),
        .M_AXI_ARQOS(ARQOS), .M_AXI_ARUSER(ARUSER),
        .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RID(1'b0), .M_AXI_RDATA(RDATA),
        .M_AXI_RRESP(2'b00), .M_AXI_RLAST(RLAST),
        .M_AXI_RUSER(4'h0), .M_AXI_RVALID(RVALID),
        .M_AXI_RREADY(RREADY)
    );

    // AXI read slave
    logic        ar_ready_en;
    logic        pending;
    logic [31:0] raddr;
    logic [31:0] wr_next;
    int          rem;
    int          ar_cnt;
    logic [31:0] ar_addr_log [256];
    logic [7:0]  ar_len_log  [256];

    assign ARREADY = ar_ready_en & ~pending;
    assign RVALID  = pending;
    assign RLAST   = (rem == 1);
    assign RDATA   = 32'h1000_0000 + {2'b00, raddr[31:2]};

    always @(posedge CLK) begin
        if (RST) begin
            pending <= 1'b0;
            rem     <= 0;
        end else begin
            if (RVALID && RREADY) begin
                raddr   <= raddr + 32'd4;
                wr_next <= raddr + 32'd4;
                rem     <= rem - 1;
                if (rem == 1) pending <= 1'b0;
            end
            if (ARVALID && ARREADY) begin
                pending <= 1'b1;
                raddr   <= ARADDR;
                rem     <= int'(ARLEN) + 1;
                ar_addr_log[ar_cnt[7:0]] <= ARADDR;
                ar_len_log[ar_cnt[7:0]]  <= ARLEN;
                ar_cnt  <= ar_cnt + 1;
            end
        end
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic        mon_on = 1'b0;
    logic [31:0] exp_pc = 32'h0;
    int          arv_cycles = 0;
    int          base;
    logic        ok;
    logic [31:0] hold_addr;
    logic [31:0] burst_end;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample at negedge (head consumer model), then return just after posedge.
    task automatic tick();
        @(negedge CLK);
        if (mon_on && I_VALID && !STALL && !FLUSH) begin
            chk("head_pc", I_PC, exp_pc);
            chk("head_inst", I_INST, 32'h1000_0000 + {2'b00, exp_pc[31:2]});
            exp_pc += 32'd4;
        end
        if (ARVALID) arv_cycles++;
        @(posedge CLK);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_ar(input int target, input string tag);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ar_cnt >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_quiet();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!pending && !ARVALID) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("quiet_wait", 32'(ok), 32'd1);
    endtask

    task automatic wait_beat(input int r);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (RVALID && RREADY && rem == r) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("beat_wait", 32'(ok), 32'd1);
    endtask

    // Redirect while idle; check the clipped first burst and the next one.
    task automatic redirect(input logic [31:0] pc, input logic [7:0] len0,
                            input logic [31:0] addr1);
        EXEC = 1'b0;
        wait_quiet();
        run(2);
        FLUSH    = 1'b1;
        FLUSH_PC = pc;
        exp_pc   = pc;
        base     = ar_cnt;
        tick();
        FLUSH = 1'b0;
        EXEC  = 1'b1;
        #1;
        chk("flush_empty_wait", 32'(MEM_WAIT), 32'd1);
        wait_ar(base + 2, "redir_ar_wait");
        chk("redir_addr0", ar_addr_log[base[7:0]], pc);
        chk("redir_len0", 32'(ar_len_log[base[7:0]]), 32'(len0));
        chk("redir_addr1", ar_addr_log[8'(base + 1)], addr1);
        chk("redir_len1", 32'(ar_len_log[8'(base + 1)]), 32'd3);
        run(12);
    endtask

    initial begin
        RST = 1'b1; EXEC = 1'b0; STALL = 1'b0;
        FLUSH = 1'b0; FLUSH_PC = 32'h0;
        ar_ready_en = 1'b1; ar_cnt = 0;
        raddr = 32'h0; wr_next = 32'h0;
        run(2);
        chk("rst_arvalid", 32'(ARVALID), 32'd0);
        chk("rst_rready", 32'(RREADY), 32'd0);
        chk("rst_ivalid", 32'(I_VALID), 32'd0);
        chk("rst_araddr", ARADDR, 32'h0);
        chk("rst_arlen", 32'(ARLEN), 32'd0);
        chk("rst_ipc", I_PC, 32'h0);
        chk("rst_iinst", I_INST, 32'h0);
        chk("rst_memwait0", 32'(MEM_WAIT), 32'd0);
        EXEC = 1'b1;
        #1;
        chk("rst_memwait1", 32'(MEM_WAIT), 32'd1);

        // Stream from reset PC
        RST = 1'b0; exp_pc = 32'h0; mon_on = 1'b1;
        tick();
        chk("ar1_valid", 32'(ARVALID), 32'd1);
        chk("ar1_addr", ARADDR, 32'h0);
        chk("ar1_len", 32'(ARLEN), 32'd3);
        chk("ar1_cache", 32'(ARCACHE), 32'h3);
        chk("ar1_size", 32'(ARSIZE), 32'h2);
        chk("ar1_burst", 32'(ARBURST), 32'h1);
        chk("prime_wait", 32'(MEM_WAIT), 32'd1);
        tick();
        chk("data_rready", 32'(RREADY), 32'd1);
        chk("data_wait", 32'(MEM_WAIT), 32'd1);
        tick();
        chk("first_valid", 32'(I_VALID), 32'd1);
        chk("first_pc", I_PC, 32'h0);
        chk("first_nowait", 32'(MEM_WAIT), 32'd0);
        run(40);

        // Stall: FIFO fills to depth, no requests once full
        STALL = 1'b1;
        run(10);
        arv_cycles = 0;
        run(10);
        chk("stall_fill", (wr_next - exp_pc) >> 2, 32'd8);
        chk("stall_no_ar", 32'(arv_cycles), 32'd0);
        chk("stall_head", I_PC, exp_pc);
        chk("stall_valid", 32'(I_VALID), 32'd1);
        STALL = 1'b0;
        run(30);

        // 4 KB page clip and 32-bit wrap
        redirect(32'h0000_0FF8, 8'd1, 32'h0000_1000);
        redirect(32'hFFFF_FFF8, 8'd1, 32'h0000_0000);

        // Flush during the second beat of a 4-beat burst
        wait_beat(3);
        FLUSH = 1'b1; FLUSH_PC = 32'h200; exp_pc = 32'h200;
        base = ar_cnt;
        tick();
        FLUSH = 1'b0;
        chk("fl_empty", 32'(I_VALID), 32'd0);
        chk("fl_drain_rready", 32'(RREADY), 32'd1);
        wait_ar(base + 1, "fl_ar_wait");
        chk("fl_addr", ar_addr_log[base[7:0]], 32'h200);
        chk("fl_len", 32'(ar_len_log[base[7:0]]), 32'd3);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (I_VALID) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("fl_valid_wait", 32'(ok), 32'd1);
        chk("fl_first_pc", I_PC, 32'h200);
        run(20);

        // Flush while the address phase is stalled by the slave
        ar_ready_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ARVALID) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("arv_wait", 32'(ok), 32'd1);
        hold_addr = ARADDR;
        FLUSH = 1'b1; FLUSH_PC = 32'h300; exp_pc = 32'h300;
        base = ar_cnt;
        tick();
        FLUSH = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_arvalid", 32'(ARVALID), 32'd1);
            chk("hold_araddr", ARADDR, hold_addr);
            tick();
        end
        ar_ready_en = 1'b1;
        wait_ar(base + 2, "hold_ar_wait");
        chk("hold_drained", ar_addr_log[base[7:0]], hold_addr);
        chk("hold_next", ar_addr_log[8'(base + 1)], 32'h300);
        run(20);

        // EXEC dropped mid-burst: burst completes, entries retained
        wait_beat(3);
        burst_end = raddr + 32'(rem * 4);
        EXEC = 1'b0;
        arv_cycles = 0;
        wait_quiet();
        run(6);
        chk("ex_ivalid", 32'(I_VALID), 32'd0);
        chk("ex_no_ar", 32'(arv_cycles), 32'd0);
        chk("ex_nowait", 32'(MEM_WAIT), 32'd0);
        chk("ex_burst_done", wr_next, burst_end);
        EXEC = 1'b1;
        #1;
        chk("ex_resume_valid", 32'(I_VALID), 32'd1);
        chk("ex_resume_pc", I_PC, exp_pc);
        run(20);

        // Reset in the middle of a burst
        wait_beat(2);
        mon_on = 1'b0;
        RST = 1'b1;
        tick();
        chk("mrst_arvalid", 32'(ARVALID), 32'd0);
        chk("mrst_rready", 32'(RREADY), 32'd0);
        chk("mrst_ivalid", 32'(I_VALID), 32'd0);
        chk("mrst_ipc", I_PC, 32'h0);
        chk("mrst_araddr", ARADDR, 32'h0);
        base = ar_cnt;
        RST = 1'b0; exp_pc = 32'h0; mon_on = 1'b1;
        wait_ar(base + 1, "mrst_ar_wait");
        chk("mrst_addr", ar_addr_log[base[7:0]], 32'h0);
        run(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
